adc_pulse_pattern_gen: RTL

Synthetic ADC source for the ESTHER trigger path. It drives four channels of packed two-sample ADC words, using the same data/enable/valid interface the trigger generator consumes. On command it emits a programmable three-pulse sequence: a rising pulse on channel A, a negative-going pulse on channel B, then a second rising pulse on channel A. It sits in place of, or muxed ahead of, the real ADC capture so that trigger thresholds and the measured pulse delay can be exercised in hardware without a shot.

---
 rtl/adc_pulse_pattern_gen.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_pulse_pattern_gen.sv
// Synthetic four-channel ADC source that emits a programmable three-pulse
// sequence (A rising, B falling, A rising) for exercising the trigger path.
module adc_pulse_pattern_gen #(
    parameter int ADC_DATA_WIDTH = 16,
    parameter int CNT_WIDTH      = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        gen_enable,
    input  logic                        gen_start,
    input  logic                        gen_repeat,
    input  logic [ADC_DATA_WIDTH-1:0]   baseline,
    input  logic [3*ADC_DATA_WIDTH-1:0] amp_arr,
    input  logic [15:0]                 width,
    input  logic [CNT_WIDTH-1:0]        delay_01,
    input  logic [CNT_WIDTH-1:0]        delay_12,
    input  logic [CNT_WIDTH-1:0]        idle_gap,
    output logic [2*ADC_DATA_WIDTH-1:0] adc_data_a,
    output logic [2*ADC_DATA_WIDTH-1:0] adc_data_b,
    output logic [2*ADC_DATA_WIDTH-1:0] adc_data_c,
    output logic [2*ADC_DATA_WIDTH-1:0] adc_data_d,
    output logic                        adc_enable_a,
    output logic                        adc_enable_b,
    output logic                        adc_enable_c,
    output logic                        adc_enable_d,
    output logic                        adc_valid_a,
    output logic                        adc_valid_b,
    output logic                        adc_valid_c,
    output logic                        adc_valid_d,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 seq_count
);

    localparam int DW = ADC_DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE, PULSE0, WAIT1, PULSE1, WAIT2, PULSE2, GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 start_q;
    logic                 start_edge;

    logic [DW-1:0]        base_q, amp0_q, amp1_q, amp2_q;
    logic [CNT_WIDTH-1:0] w_q, d01_q, d12_q, gap_q;
    logic [CNT_WIDTH-1:0] w_live;

    logic                 latch_cfg;
    logic                 seq_end, seq_end_done;
    logic                 end_q, end_done_q;

    logic [DW-1:0]        lvl_a, lvl_b, lvl_base;

    assign start_edge = gen_start & ~start_q;
    assign w_live     = (width == 16'd0) ? CNT_ONE : CNT_WIDTH'(width);

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
        latch_cfg    = 1'b0;
        seq_end      = 1'b0;
        seq_end_done = 1'b0;

        if (!gen_enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start_edge) begin
                    state_d   = PULSE0;
                    cnt_d     = w_live - CNT_ONE;
                    latch_cfg = 1'b1;
                end
                PULSE0: if (cnt_q == '0) begin
                    if (d01_q > w_q) begin
                        state_d = WAIT1;
                        cnt_d   = d01_q - w_q - CNT_ONE;
                    end else begin
                        state_d = PULSE1;
                        cnt_d   = w_q - CNT_ONE;
                    end
                end
                WAIT1: if (cnt_q == '0) begin
                    state_d = PULSE1;
                    cnt_d   = w_q - CNT_ONE;
                end
                PULSE1: if (cnt_q == '0) begin
                    if (d12_q > w_q) begin
                        state_d = WAIT2;
                        cnt_d   = d12_q - w_q - CNT_ONE;
                    end else begin
                        state_d = PULSE2;
                        cnt_d   = w_q - CNT_ONE;
                    end
                end
                WAIT2: if (cnt_q == '0) begin
                    state_d = PULSE2;
                    cnt_d   = w_q - CNT_ONE;
                end
                PULSE2: if (cnt_q == '0) begin
                    seq_end = 1'b1;
                    if (!gen_repeat) begin
                        state_d      = IDLE;
                        seq_end_done = 1'b1;
                    end else if (gap_q != '0) begin
                        state_d = GAP;
                        cnt_d   = gap_q - CNT_ONE;
                    end else begin
                        state_d   = PULSE0;
                        cnt_d     = w_live - CNT_ONE;
                        latch_cfg = 1'b1;
                    end
                end
                GAP: if (cnt_q == '0) begin
                    state_d   = PULSE0;
                    cnt_d     = w_live - CNT_ONE;
                    latch_cfg = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Channel levels from the current state; IDLE follows baseline live.
    always_comb begin
        lvl_base = (state_q == IDLE) ? baseline : base_q;
        lvl_a    = lvl_base;
        lvl_b    = lvl_base;
        if (state_q == PULSE0) lvl_a = amp0_q;
        if (state_q == PULSE2) lvl_a = amp2_q;
        if (state_q == PULSE1) lvl_b = amp1_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            start_q    <= 1'b1;
            end_q      <= 1'b0;
            end_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            start_q    <= gen_start;
            end_q      <= seq_end;
            end_done_q <= seq_end_done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            amp0_q <= '0;
            amp1_q <= '0;
            amp2_q <= '0;
            w_q    <= CNT_ONE;
            d01_q  <= '0;
            d12_q  <= '0;
            gap_q  <= '0;
        end else if (latch_cfg) begin
            base_q <= baseline;
            amp0_q <= amp_arr[DW-1:0];
            amp1_q <= amp_arr[2*DW-1:DW];
            amp2_q <= amp_arr[3*DW-1:2*DW];
            w_q    <= w_live;
            d01_q  <= delay_01;
            d12_q  <= delay_12;
            gap_q  <= idle_gap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_data_a   <= '0;
            adc_data_b   <= '0;
            adc_data_c   <= '0;
            adc_data_d   <= '0;
            adc_enable_a <= 1'b0;
            adc_enable_b <= 1'b0;
            adc_enable_c <= 1'b0;
            adc_enable_d <= 1'b0;
            adc_valid_a  <= 1'b0;
            adc_valid_b  <= 1'b0;
            adc_valid_c  <= 1'b0;
            adc_valid_d  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            seq_count    <= '0;
        end else begin
            adc_data_a   <= {lvl_a, lvl_a};
            adc_data_b   <= {lvl_b, lvl_b};
            adc_data_c   <= {lvl_base, lvl_base};
            adc_data_d   <= {lvl_base, lvl_base};
            adc_enable_a <= 1'b1;
            adc_enable_b <= 1'b1;
            adc_enable_c <= 1'b1;
            adc_enable_d <= 1'b1;
            adc_valid_a  <= 1'b1;
            adc_valid_b  <= 1'b1;
            adc_valid_c  <= 1'b1;
            adc_valid_d  <= 1'b1;
            busy         <= (state_q != IDLE);
            done         <= end_done_q;
            if (end_q) seq_count <= seq_count + 16'd1;
        end
    end

endmodule
